// File: rtl/drive_actuator_if.sv
// Command handshake between the driving controller (master) and the drive actuator (slave).
// Carries a valid/ready qualified {handle, engine} command.
interface drive_actuator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_handle;
    logic [3:0] cmd_engine;

    modport master (output cmd_valid, output cmd_handle, output cmd_engine, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_handle, input cmd_engine, output cmd_ready);
endinterface

// File: rtl/drive_actuator.sv
// Drive actuator: latches handle/engine commands and ramps the speed code toward the target.
// Optional emergency stop input and latch are built when DRIVE_ESTOP_EN is defined.
module drive_actuator #(
    parameter int STEP_CYCLES  = 4,
    parameter int BRAKE_CYCLES = 1,
    parameter int TURN_MAX     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef DRIVE_ESTOP_EN
    input  logic                    estop,
`endif
    drive_actuator_if.slave         cmd,
    output logic [3:0]              speed,
    output logic [1:0]              steer,
    output logic                    brake,
    output logic                    at_target,
    output logic                    cmd_err
);

    localparam int CNT_MAX = (STEP_CYCLES > BRAKE_CYCLES) ? STEP_CYCLES : BRAKE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
    localparam logic [3:0]       TURN_LIM   = 4'(TURN_MAX);

    typedef enum logic [1:0] {IDLE, ACCEL, DECEL, CRUISE} state_t;

    function automatic logic [3:0] limit_turn(input logic [3:0] t, input logic [1:0] h);
        if (h != 2'b00 && t > TURN_LIM) return TURN_LIM;
        return t;
    endfunction

    function automatic logic [3:0] sat_dec2(input logic [3:0] s);
        return (s >= 4'd2) ? s - 4'd2 : 4'd0;
    endfunction

    function automatic state_t classify(input logic [3:0] s, input logic [3:0] e);
        if (s < e)      return ACCEL;
        if (s > e)      return DECEL;
        if (s == 4'd0)  return IDLE;
        return CRUISE;
    endfunction

    state_t           state, state_next;
    logic [3:0]       tgt, tgt_next;
    logic [1:0]       hdl, hdl_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       speed_next;
    logic             err_next;
    logic             accept;
    logic             active;

`ifdef DRIVE_ESTOP_EN
    logic latch;

    // The stop stays in force after estop drops until the vehicle is at standstill.
    assign active = estop | (latch & (speed != 4'd0));

    always_ff @(posedge clk) begin
        if (reset) latch <= 1'b0;
        else       latch <= active;
    end
`else
    assign active = 1'b0;
`endif

    assign cmd.cmd_ready = ~active;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign at_target     = (speed == limit_turn(tgt, hdl));
    assign brake         = (state == DECEL) | active;
    assign steer         = (active || speed > TURN_LIM) ? 2'b00 : hdl;

    always_comb begin
        speed_next = speed;
        tgt_next   = tgt;
        hdl_next   = hdl;
        cnt_next   = cnt;
        err_next   = 1'b0;
        if (active) begin
            speed_next = sat_dec2(speed);
            tgt_next   = 4'd0;
            cnt_next   = '0;
        end else if (accept) begin
            // A command always wins over a pending step tick and restarts the count.
            tgt_next = cmd.cmd_engine;
            hdl_next = (cmd.cmd_handle == 2'b11) ? 2'b00 : cmd.cmd_handle;
            cnt_next = '0;
            err_next = (cmd.cmd_handle == 2'b11);
        end else begin
            unique case (state)
                ACCEL: begin
                    if (cnt == STEP_LAST) begin
                        speed_next = speed + 4'd1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                DECEL: begin
                    if (cnt == BRAKE_LAST) begin
                        speed_next = speed - 4'd1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: cnt_next = '0;
            endcase
        end
        state_next = classify(speed_next, limit_turn(tgt_next, hdl_next));
        if (state_next != state) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            speed   <= 4'd0;
            tgt     <= 4'd0;
            hdl     <= 2'b00;
            cnt     <= '0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_next;
            speed   <= speed_next;
            tgt     <= tgt_next;
            hdl     <= hdl_next;
            cnt     <= cnt_next;
            cmd_err <= err_next;
        end
    end

endmodule

// File: tb/tb_drive_actuator.sv
// Directed bench for drive_actuator with STEP_CYCLES=4, BRAKE_CYCLES=1, TURN_MAX=2.
// Emergency-stop vectors are included when DRIVE_ESTOP_EN is defined.
module tb_drive_actuator;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] speed;
    logic [1:0] steer;
    logic       brake;
    logic       at_target;
    logic       cmd_err;
`ifdef DRIVE_ESTOP_EN
    logic       estop;
`endif

    int tests  = 0;
    int errors = 0;

    drive_actuator_if cmd_bus ();

    drive_actuator #(
        .STEP_CYCLES  (4),
        .BRAKE_CYCLES (1),
        .TURN_MAX     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DRIVE_ESTOP_EN
        .estop     (estop),
`endif
        .cmd       (cmd_bus.slave),
        .speed     (speed),
        .steer     (steer),
        .brake     (brake),
        .at_target (at_target),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one accepting edge.
    task automatic send(input logic [1:0] h, input logic [3:0] e);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_handle = h;
        cmd_bus.cmd_engine = e;
        tick();
        cmd_bus.cmd_valid  = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_handle = 2'b00;
        cmd_bus.cmd_engine = 4'd0;
`ifdef DRIVE_ESTOP_EN
        estop              = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_speed", speed, 0);
        check_eq("rst_steer", steer, 0);
        check_eq("rst_brake", brake, 0);
        check_eq("rst_at_target", at_target, 1);
        check_eq("rst_cmd_ready", cmd_bus.cmd_ready, 1);
        check_eq("rst_cmd_err", cmd_err, 0);

        // Straight ramp 0 -> 4: one code every 4 edges after the accept edge.
        send(2'b00, 4'd4);
        check_eq("acc_speed_0", speed, 0);
        check_eq("acc_at_target_0", at_target, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq($sformatf("ramp_speed_%0d", k), speed, k / 4);
            if (k == 15) check_eq("ramp_at_target_15", at_target, 0);
        end
        check_eq("ramp_at_target_16", at_target, 1);
        check_eq("ramp_brake_16", brake, 0);

        // Left turn request at speed 4: brake down to the turn limit of 2.
        send(2'b01, 4'd4);
        check_eq("turn_brake_0", brake, 1);
        check_eq("turn_speed_0", speed, 4);
        check_eq("turn_steer_0", steer, 0);
        tick();
        check_eq("turn_speed_1", speed, 3);
        check_eq("turn_brake_1", brake, 1);
        check_eq("turn_steer_1", steer, 0);
        tick();
        check_eq("turn_speed_2", speed, 2);
        check_eq("turn_steer_2", steer, 1);
        check_eq("turn_brake_2", brake, 0);
        check_eq("turn_at_target_2", at_target, 1);
        tick();
        check_eq("turn_hold_speed", speed, 2);

        // Illegal handle: one-cycle error, straight steering, ramp to 3.
        send(2'b11, 4'd3);
        check_eq("ill_cmd_err_0", cmd_err, 1);
        check_eq("ill_steer_0", steer, 0);
        check_eq("ill_speed_0", speed, 2);
        tick();
        check_eq("ill_cmd_err_1", cmd_err, 0);
        tick();
        tick();
        check_eq("ill_speed_3", speed, 2);
        tick();
        check_eq("ill_speed_4", speed, 3);
        check_eq("ill_at_target_4", at_target, 1);

        // Reset in the middle of a ramp from 3 toward 9.
        send(2'b00, 4'd9);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_speed", speed, 0);
        check_eq("midrst_at_target", at_target, 1);
        check_eq("midrst_brake", brake, 0);
        for (int k = 0; k < 6; k++) tick();
        check_eq("midrst_no_step", speed, 0);

        // A command landing on the step edge wins and restarts the count.
        send(2'b00, 4'd5);
        tick();
        tick();
        tick();
        send(2'b00, 4'd6);
        check_eq("overlap_speed_0", speed, 0);
        tick();
        tick();
        tick();
        check_eq("overlap_speed_3", speed, 0);
        tick();
        check_eq("overlap_speed_4", speed, 1);

        // Right turn with a high target: speed capped at 2, steering applied at low speed.
        send(2'b10, 4'd9);
        check_eq("rturn_steer_0", steer, 2);
        check_eq("rturn_speed_0", speed, 1);
        for (int k = 0; k < 4; k++) tick();
        check_eq("rturn_speed_4", speed, 2);
        check_eq("rturn_at_target_4", at_target, 1);
        for (int k = 0; k < 4; k++) tick();
        check_eq("rturn_cap_speed", speed, 2);
        check_eq("rturn_cap_steer", steer, 2);

        // Handle back to straight: steering releases next cycle, speed climbs to 7.
        send(2'b00, 4'd9);
        check_eq("release_steer", steer, 0);
        check_eq("release_at_target", at_target, 0);
        for (int k = 0; k < 20; k++) tick();
        check_eq("climb_speed_7", speed, 7);

`ifdef DRIVE_ESTOP_EN
        estop = 1'b1;
        tick();
        check_eq("estop_speed_5", speed, 5);
        check_eq("estop_ready_5", cmd_bus.cmd_ready, 0);
        check_eq("estop_brake_5", brake, 1);
        tick();
        check_eq("estop_speed_3", speed, 3);
        tick();
        check_eq("estop_speed_1", speed, 1);
        tick();
        check_eq("estop_speed_0", speed, 0);
        check_eq("estop_ready_0", cmd_bus.cmd_ready, 0);
        estop = 1'b0;
        tick();
        check_eq("estop_clear_ready", cmd_bus.cmd_ready, 1);
        check_eq("estop_clear_speed", speed, 0);
        check_eq("estop_clear_brake", brake, 0);
        check_eq("estop_clear_at_target", at_target, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
